// File: rtl/inversor_pkg.sv
// Shared types for the round-robin arbiter around the 4-bit inversor.
// Operand width, data type and arbiter sequence states live here.
package inversor_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  function automatic data_t slice_data(
    input logic [8*DATA_W-1:0] bus,
    input int unsigned         idx
  );
    return bus[idx*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/inversor_arbiter_if.sv
// Requester-side bus of the inversor arbiter.
// Master is the client cluster, slave is the arbiter.
interface inversor_arbiter_if
  import inversor_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) ();

  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  data_t                  rsp_data;

  modport master (
    output req,
    output req_data,
    input  gnt,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_data
  );

  modport slave (
    input  req,
    input  req_data,
    output gnt,
    output rsp_valid,
    output rsp_id,
    output rsp_data
  );

endinterface

// File: rtl/inversor.sv
// Shared 4-bit combinational datapath: bitwise inversion.
// Kept as its own module so the arbiter is the only user.
module inversor
  import inversor_pkg::*;
(
  input  data_t a,
  output data_t y
);

  assign y = ~a;

endmodule

// File: rtl/inversor_arbiter_rr_picker.sv
// Round-robin priority rotation: first asserted request after ptr.
// Purely combinational; returns a one-hot pick and its index.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] pick,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic            found;
  logic [ID_W-1:0] j;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    // ptr itself is scanned last, so the last winner has lowest priority
    for (int k = 1; k <= NREQ; k++) begin
      j = ID_W'((int'(ptr) + k) % NREQ);
      if (!found && req[j]) begin
        found   = 1'b1;
        pick[j] = 1'b1;
        idx     = j;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/inversor_arbiter.sv
// Round-robin front end sharing one inversor among NREQ clients.
// Sequence per operation: IDLE (grant) -> EXEC -> RESP.
module inversor_arbiter
  import inversor_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  inversor_arbiter_if.slave   bus,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  arb_state_t      state_q;
  arb_state_t      state_d;
  data_t           opnd_q;
  data_t           inv_y;
  data_t           rdata_q;
  logic [ID_W-1:0] cur_q;
  logic [ID_W-1:0] rid_q;
  logic [ID_W-1:0] ptr_q;
  cnt_t            cnt_q;

  logic [NREQ-1:0] pick;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic            take;
  logic [NREQ-1:0] gnt_c;
  logic            rv_c;

  rr_picker #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  inversor u_inv (
    .a (opnd_q),
    .y (inv_y)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    gnt_c   = '0;
    rv_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rst gates the grant so none leaks out while held in reset
        if (rst && en && pick_any) begin
          take    = 1'b1;
          gnt_c   = pick;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        rv_c    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      cur_q   <= '0;
      ptr_q   <= ID_W'(NREQ - 1);
      rdata_q <= '0;
      rid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        opnd_q <= data_t'(
          bus.req_data[pick_idx*DATA_W +: DATA_W]);
        cur_q  <= pick_idx;
        ptr_q  <= pick_idx;
      end
      if (state_q == EXEC) begin
        rdata_q <= inv_y;
        rid_q   <= cur_q;
      end
      if (state_q == RESP) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.rsp_valid = rv_c;
  assign bus.rsp_id    = rid_q;
  assign bus.rsp_data  = rdata_q;
  assign busy          = (state_q != IDLE);
  assign op_count      = cnt_q;

endmodule

// File: doc/inversor_arbiter.md
Name: inversor_arbiter

Overview:
- Shares one instance of the existing 4-bit combinational `inversor` datapath between NREQ independent requesters.
- Arbitration is round-robin.
- Each operation runs as a 3-state sequence:
  - capture the winner's operand;
  - register the inverted result;
  - return it tagged with the requester id.
- Sits between client blocks and the shared inversor, so clients never drive the datapath directly.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, $clog2(NREQ), width of the requester id.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- en  in  1  grant enable; when low, no new grants are issued and an in-flight operation still completes.
- req  in  NREQ  per-requester request level.
- req_data  in  NREQ*DATA_W  per-requester operand; requester i uses bits [i*DATA_W +: DATA_W].
- gnt  out  NREQ  one-hot grant pulse, one cycle wide.
- rsp_valid  out  1  result-valid pulse, one cycle wide.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  DATA_W  inverted operand (~operand).
- busy  out  1  high while state != IDLE.
- op_count  out  16  number of completed operations; wraps from 0xFFFF to 0.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is asynchronous and active-low.
- Reset values:
  - gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, op_count=0.
  - State=IDLE; rr_ptr=NREQ-1, so requester 0 has first priority.
  - Operand register = 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Taken when en=1 and |req=1:
    - Choose the first asserted req scanning rr_ptr+1, rr_ptr+2, … modulo NREQ.
    - Drive gnt[winner]=1 combinationally in this cycle.
    - On the edge: operand <= req_data[winner]; cur_id <= winner; rr_ptr <= winner; go to EXEC.
  - Otherwise stay in IDLE with gnt=0.
- EXEC:
  - Operand drives inversor.a.
  - On the edge: rsp_data <= inversor.y; rsp_id <= cur_id; go to RESP.
- RESP:
  - rsp_valid=1 for exactly this cycle.
  - On the edge: op_count <= op_count+1; go to IDLE.
- Timing:
  - Latency is fixed: gnt in cycle T gives rsp_valid in cycle T+2.
  - Peak throughput is one operation per 3 cycles; the next gnt comes no earlier than T+3.
- Requester rules:
  - Hold req and req_data stable until gnt is seen.
  - Drop req in the cycle after gnt, unless another operation is wanted.
  - req dropped before gnt is simply not considered; no error is raised.
- rsp_data and rsp_id hold their value after RESP until the next EXEC overwrites them.
- gnt is only ever asserted in IDLE. It is never asserted while busy=1.
- en:
  - Sampled only in IDLE.
  - en falling during EXEC/RESP does not abort the operation.
- Boundary conditions:
  - All req high continuously: grants rotate 0,1,2,…,NREQ-1,0,…
  - Only one requester active: it is granted every 3 cycles.
  - Same requester re-requests immediately after its gnt: it gets lowest priority in the next arbitration.
  - rst asserted mid-operation: the in-flight result is discarded and no rsp_valid is produced. After release, arbitration restarts from requester 0.
  - op_count wraps silently.

Decomposition:
- Package `inversor_pkg`:
  - localparam DATA_W=4;
  - typedef logic [DATA_W-1:0] data_t;
  - typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t.
- Sub-modules:
  - The existing `inversor` is instantiated inside (ports .a, .y).
  - One sub-module, `rr_picker` (combinational: req, rr_ptr -> one-hot pick plus index), holds the priority-rotation logic.

Test Plan:
1. Reset: hold rst=0 for 2 cycles while req=4'b1111 -> gnt=0, rsp_valid=0, op_count=0, busy=0.
2. Single request: req=4'b0100, req_data[2]=4'b0011, en=1 -> gnt=4'b0100 at T; rsp_valid at T+2 with rsp_id=2, rsp_data=4'b1100; op_count=1.
3. Round-robin: req=4'b1111 held for 12 cycles, data_i=i -> grant order 0,1,2,3; responses 1111, 1110, 1101, 1100; op_count=4.
4. en gating: en=0 with req=4'b0001 for 5 cycles -> no gnt. Raise en -> gnt=4'b0001 next cycle. Drop en during EXEC -> rsp_valid still occurs.
5. Mid-op reset: grant requester 1 (data 4'b1010), assert rst in EXEC -> no rsp_valid, all outputs 0. After release with req=4'b0011 -> requester 0 is granted first.
6. Wrap: force 65536 operations on requester 3 (data 4'b0000) -> every rsp_data=4'b1111 and op_count returns to 0.
